// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   localparam int INSTR_W = 32;

   // Canonical RISC-V no-op (addi x0, x0, 0)
   localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

   // PC width used by the shared entry type (the default core XLEN)
   localparam int FETCH_XLEN = 32;

   // One fetched instruction together with the address it came from
   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [INSTR_W-1:0]    instr;
   } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_buffer.sv
// In-order prefetch queue. An entry is allocated (PC known) when the memory
// grants a request, filled (instruction known) when the response returns and
// released when decode takes it. Three independent pointers walk the ring;
// a flush empties the whole queue in one cycle.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               i_flush,
   input  logic               i_alloc,
   input  logic [XLEN-1:0]    i_alloc_pc,
   input  logic               i_fill,
   input  logic [INSTR_W-1:0] i_fill_instr,
   input  logic               i_pop,
   output logic               o_full,
   output logic               o_head_vld,
   output logic [XLEN-1:0]    o_head_pc,
   output logic [INSTR_W-1:0] o_head_instr
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [XLEN-1:0]    r_pc    [DEPTH];
   logic [INSTR_W-1:0] r_instr [DEPTH];
   logic [DEPTH-1:0]   r_filled;
   logic [PTR_W-1:0]   r_alloc_ptr;
   logic [PTR_W-1:0]   r_fill_ptr;
   logic [PTR_W-1:0]   r_read_ptr;
   logic [CNT_W-1:0]   r_count;

   // Ring pointers, filled flags and occupancy; a flush outranks alloc/fill/pop
   always_ff @(posedge clk_i) begin
      if (rst_i || i_flush) begin
         r_alloc_ptr <= '0;
         r_fill_ptr  <= '0;
         r_read_ptr  <= '0;
         r_count     <= '0;
         r_filled    <= '0;
      end else begin
         if (i_alloc) begin
            r_alloc_ptr           <= r_alloc_ptr + PTR_W'(1);
            r_filled[r_alloc_ptr] <= 1'b0;
         end
         if (i_fill) begin
            r_fill_ptr           <= r_fill_ptr + PTR_W'(1);
            r_filled[r_fill_ptr] <= 1'b1;
         end
         if (i_pop) begin
            r_read_ptr           <= r_read_ptr + PTR_W'(1);
            r_filled[r_read_ptr] <= 1'b0;
         end
         case ({i_alloc, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry payload: PC written on allocate, instruction written on fill
   always_ff @(posedge clk_i) begin
      if (rst_i || i_flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_pc[i]    <= '0;
            r_instr[i] <= '0;
         end
      end else begin
         if (i_alloc) begin
            r_pc[r_alloc_ptr] <= i_alloc_pc;
         end
         if (i_fill) begin
            r_instr[r_fill_ptr] <= i_fill_instr;
         end
      end
   end

   // Allocated entries are counted, not filled ones, so a full queue also
   // covers slots still waiting on memory.
   assign o_full       = (r_count == FULL_CNT);
   assign o_head_vld   = r_filled[r_read_ptr];
   assign o_head_pc    = r_pc[r_read_ptr];
   assign o_head_instr = r_instr[r_read_ptr];

endmodule : fetch_buffer

// File: rtl/prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues requests to a
// variable-latency instruction memory, tracks outstanding requests and
// discards responses that belong to a fetch stream killed by a redirect.
module prefetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN            = 32,
   parameter int              DEPTH           = 4,
   parameter int              MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = '0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   output logic               imem_req_o,
   output logic [XLEN-1:0]    imem_addr_o,
   input  logic               imem_gnt_i,
   input  logic               imem_rvalid_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   input  logic               redirect_i,
   input  logic [XLEN-1:0]    redirect_pc_i,
   output logic               id_valid_o,
   output logic [XLEN-1:0]    id_pc_o,
   output logic [INSTR_W-1:0] id_instr_o,
   input  logic               id_ready_i
);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("prefetch_unit: DEPTH must be a power of two and at least 2");
   end
   if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > DEPTH)) begin : g_bad_os
      $error("prefetch_unit: MAX_OUTSTANDING must lie in 1..DEPTH");
   end
   if (RESET_PC[1:0] != 2'b00) begin : g_bad_rst_pc
      $error("prefetch_unit: RESET_PC must be word aligned");
   end

   localparam int OS_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OS_W-1:0] OS_MAX = OS_W'(MAX_OUTSTANDING);

   logic [XLEN-1:0] r_fpc;
   logic [OS_W-1:0] r_outstanding;
   logic [OS_W-1:0] r_drop_cnt;

   logic               w_full;
   logic               w_head_vld;
   logic [XLEN-1:0]    w_head_pc;
   logic [INSTR_W-1:0] w_head_instr;
   logic               w_req;
   logic               w_gnt;
   logic               w_rsp;
   logic               w_dropping;
   logic               w_fill;
   logic               w_pop;

   // A request is offered only when a queue slot and an outstanding slot are
   // both free; reset and redirect suppress it so a stale PC never leaks out.
   assign w_req = start_i & ~redirect_i & ~rst_i & ~w_full & (r_outstanding < OS_MAX);
   assign w_gnt = w_req & imem_gnt_i;

   // A response with nothing outstanding is a memory protocol error and is ignored.
   assign w_rsp      = imem_rvalid_i & (r_outstanding != '0);
   assign w_dropping = (r_drop_cnt != '0);
   assign w_fill     = w_rsp & ~w_dropping & ~redirect_i;
   assign w_pop      = w_head_vld & id_ready_i & ~redirect_i;

   // Fetch PC: word-aligned redirect target, else step past each granted request
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fpc <= RESET_PC;
      end else if (redirect_i) begin
         r_fpc <= {redirect_pc_i[XLEN-1:2], 2'b00};
      end else if (w_gnt) begin
         r_fpc <= r_fpc + XLEN'(4);
      end
   end

   // Outstanding/drop bookkeeping. Dropped requests stay counted as
   // outstanding until their responses arrive, so issue remains bounded.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         if (w_gnt && !w_rsp) begin
            r_outstanding <= r_outstanding + OS_W'(1);
         end else if (!w_gnt && w_rsp) begin
            r_outstanding <= r_outstanding - OS_W'(1);
         end
         if (redirect_i) begin
            // Everything still in flight is now stale, except a response
            // arriving this very cycle, which is consumed right here.
            r_drop_cnt <= r_outstanding - OS_W'(w_rsp);
         end else if (w_rsp && w_dropping) begin
            r_drop_cnt <= r_drop_cnt - OS_W'(1);
         end
      end
   end

   fetch_buffer #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .i_flush      (redirect_i),
      .i_alloc      (w_gnt),
      .i_alloc_pc   (r_fpc),
      .i_fill       (w_fill),
      .i_fill_instr (imem_rdata_i),
      .i_pop        (w_pop),
      .o_full       (w_full),
      .o_head_vld   (w_head_vld),
      .o_head_pc    (w_head_pc),
      .o_head_instr (w_head_instr)
   );

   assign imem_req_o  = w_req;
   assign imem_addr_o = r_fpc;
   assign id_valid_o  = w_head_vld;
   assign id_pc_o     = w_head_pc;
   assign id_instr_o  = w_head_instr;

endmodule : prefetch_unit

// File: tb/tb_prefetch_unit.sv
// Scoreboard bench for prefetch_unit: a latency-configurable memory model
// answers granted requests in order; every grant pushes the expected
// {pc, instr} and every decode handshake pops and compares it.
module tb_prefetch_unit;
   import fetch_pkg::*;

   logic        clk;
   logic        rst_i;
   logic        start_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        id_valid_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_instr_o;
   logic        id_ready_i;

   // second instance: wrap-around reset PC, memory never answers
   logic        d2_start;
   logic        d2_req;
   logic [31:0] d2_addr;
   logic        d2_gnt;
   logic        d2_rvalid;
   logic [31:0] d2_rdata;
   logic        d2_redirect;
   logic [31:0] d2_redirect_pc;
   logic        d2_valid;
   logic [31:0] d2_pc;
   logic [31:0] d2_instr;
   logic        d2_ready;

   prefetch_unit #(
      .XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_instr_o(id_instr_o),
      .id_ready_i(id_ready_i)
   );

   prefetch_unit #(
      .XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(4), .RESET_PC(32'hFFFF_FFF8)
   ) dut2 (
      .clk_i(clk), .rst_i(rst_i), .start_i(d2_start),
      .imem_req_o(d2_req), .imem_addr_o(d2_addr), .imem_gnt_i(d2_gnt),
      .imem_rvalid_i(d2_rvalid), .imem_rdata_i(d2_rdata),
      .redirect_i(d2_redirect), .redirect_pc_i(d2_redirect_pc),
      .id_valid_o(d2_valid), .id_pc_o(d2_pc), .id_instr_o(d2_instr),
      .id_ready_i(d2_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst_i)
      imem_rvalid_i |-> (dut.r_outstanding != '0));

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t        mem_q[$];
   fetch_entry_t exp_q[$];

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          lat   = 1;
   int          grants, pops;
   int          first_gnt, first_vld;
   logic        got_pop;
   logic [31:0] first_pop_pc;
   logic        prev_redir;
   logic [31:0] exp_fpc;
   logic [31:0] d2_exp [3];
   int          d2_n = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ INSTR_NOP;
   endfunction

   // One clock cycle; entered and left at the falling edge with inputs set by the caller.
   task automatic cycle();
      fetch_entry_t e;
      mreq_t        m;
      logic         do_gnt, do_rsp, do_pop;
      if (rst_i) begin
         imem_rvalid_i = 1'b0;
         mem_q.delete();
         exp_q.delete();
         #1;
      end else begin
         if (prev_redir) check("vld_after_redir", id_valid_o, 1'b0);
         if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = instr_of(mem_q[0].addr);
         end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
         end
         #1;
         if (redirect_i) check("req_in_redir", imem_req_o, 1'b0);
         if (imem_req_o) check("req_addr", imem_addr_o, exp_fpc);
         if (d2_req && d2_n < 3) begin
            check("rstpc_seq", d2_addr, d2_exp[d2_n]);
            d2_n++;
         end
         do_gnt = imem_req_o & imem_gnt_i;
         do_rsp = imem_rvalid_i;
         do_pop = id_valid_o & id_ready_i & ~redirect_i;
         if (id_valid_o && first_vld < 0) first_vld = cyc;
         if (do_pop) begin
            if (!got_pop) begin
               first_pop_pc = id_pc_o;
               got_pop      = 1'b1;
            end
            pops++;
            if (exp_q.size() == 0) begin
               check("pop_on_empty", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("pop_pc", id_pc_o, e.pc);
               check("pop_instr", id_instr_o, e.instr);
            end
         end
         if (redirect_i) begin
            exp_q.delete();
            exp_fpc = {redirect_pc_i[31:2], 2'b00};
         end
         if (do_gnt) begin
            if (first_gnt < 0) first_gnt = cyc;
            grants++;
            m.addr = imem_addr_o;
            m.due  = cyc + lat;
            mem_q.push_back(m);
            e.pc    = exp_fpc;
            e.instr = instr_of(exp_fpc);
            exp_q.push_back(e);
            exp_fpc = exp_fpc + 32'd4;
         end
         if (do_rsp) void'(mem_q.pop_front());
      end
      prev_redir = redirect_i & ~rst_i;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_i      = 1'b1;
      redirect_i = 1'b0;
      repeat (2) cycle();
      rst_i        = 1'b0;
      exp_fpc      = 32'h0;
      grants       = 0;
      pops         = 0;
      first_gnt    = -1;
      first_vld    = -1;
      got_pop      = 1'b0;
      first_pop_pc = 32'hDEAD_BEEF;
      prev_redir   = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      start_i    = 1'b0;
      id_ready_i = 1'b1;
      while ((exp_q.size() > 0 || mem_q.size() > 0) && n < 60) begin
         cycle();
         n++;
      end
      check("drain_left", 32'(exp_q.size() + mem_q.size()), 32'd0);
      check("drain_vld", id_valid_o, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      int p0, g1;
      d2_exp[0] = 32'hFFFF_FFF8;
      d2_exp[1] = 32'hFFFF_FFFC;
      d2_exp[2] = 32'h0000_0000;
      d2_start = 1'b1; d2_gnt = 1'b1; d2_rvalid = 1'b0; d2_rdata = 32'h0;
      d2_redirect = 1'b0; d2_redirect_pc = 32'h0; d2_ready = 1'b0;
      start_i = 1'b1; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
      redirect_i = 1'b0; redirect_pc_i = 32'h0; id_ready_i = 1'b1;
      prev_redir = 1'b0;

      // reset values, with start high to show reset gates the request
      rst_i = 1'b1;
      cycle();
      check("rst_req", imem_req_o, 1'b0);
      check("rst_addr", imem_addr_o, 32'h0);
      check("rst_vld", id_valid_o, 1'b0);
      check("rst_pc", id_pc_o, 32'h0);
      check("rst_instr", id_instr_o, 32'h0);
      check("rst_addr2", d2_addr, 32'hFFFF_FFF8);

      // streaming: gnt always, k = 1, decode always ready
      do_reset();
      lat = 1; start_i = 1'b1; id_ready_i = 1'b1;
      repeat (10) cycle();
      p0 = pops;
      repeat (16) cycle();
      check("throughput", 32'(pops - p0), 32'd16);
      check("latency", 32'(first_vld - first_gnt), 32'(lat + 1));
      drain();

      // back-pressure fills the queue
      do_reset();
      lat = 1; start_i = 1'b1; id_ready_i = 1'b0;
      repeat (10) cycle();
      check("full_grants", 32'(grants), 32'd4);
      check("full_req", imem_req_o, 1'b0);
      check("full_head_vld", id_valid_o, 1'b1);
      check("full_head_pc", id_pc_o, 32'h0);
      id_ready_i = 1'b1;
      cycle();
      id_ready_i = 1'b0;
      check("pop_reenable", imem_req_o, 1'b1);
      g1 = grants;
      repeat (6) cycle();
      check("one_release", 32'(grants - g1), 32'd1);
      drain();

      // redirect with two requests in flight
      do_reset();
      lat = 3; start_i = 1'b1; id_ready_i = 1'b1;
      redirect_i = 1'b1; redirect_pc_i = 32'h10;
      cycle();
      redirect_i = 1'b0;
      cycle();
      cycle();
      redirect_i = 1'b1; redirect_pc_i = 32'h103;
      cycle();
      redirect_i = 1'b0;
      repeat (8) cycle();
      drain();
      check("redir_first_pc", first_pop_pc, 32'h100);

      // redirect coincident with a response, two outstanding
      do_reset();
      lat = 2; start_i = 1'b1; id_ready_i = 1'b1;
      cycle();
      cycle();
      redirect_i = 1'b1; redirect_pc_i = 32'h200;
      cycle();
      redirect_i = 1'b0;
      repeat (8) cycle();
      drain();
      check("same_cyc_first_pc", first_pop_pc, 32'h200);

      // start dropped with two outstanding
      do_reset();
      lat = 3; start_i = 1'b1; id_ready_i = 1'b1;
      cycle();
      cycle();
      start_i = 1'b0;
      repeat (10) cycle();
      check("stop_grants", 32'(grants), 32'd2);
      check("stop_pops", 32'(pops), 32'd2);
      check("stop_fpc", imem_addr_o, 32'h8);
      check("stop_req", imem_req_o, 1'b0);
      drain();

      check("rstpc_count", 32'(d2_n), 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_prefetch_unit
